// File: rtl/wb_ctrl_pkg.sv
// ============================================================================
// Module  : wb_ctrl_pkg
// Purpose : Shared encodings for the writeback-stage controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_ctrl_pkg;

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_PC   = 2'd1;
    localparam logic [1:0] SRC_LOAD = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wb_ctrl_load_ext.sv
// ============================================================================
// Module  : wb_ctrl_load_ext
// Purpose : Load lane select and sign/zero extension from a raw doubleword.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_ctrl_load_ext
    import wb_ctrl_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [2:0]    i_funct3,
    input  logic [2:0]    i_off,
    input  logic [DW-1:0] i_rdata,
    output logic [DW-1:0] o_data
);

    // Offset bits below the lane size are dropped, so misaligned accesses truncate.
    logic [5:0]  w_byte_sh;
    logic [5:0]  w_half_sh;
    logic [5:0]  w_word_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_word;

    assign w_byte_sh = {i_off, 3'b000};
    assign w_half_sh = {i_off[2:1], 4'b0000};
    assign w_word_sh = {i_off[2], 5'b00000};
    assign w_byte    = i_rdata[w_byte_sh +: 8];
    assign w_half    = i_rdata[w_half_sh +: 16];
    assign w_word    = i_rdata[w_word_sh +: 32];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{(DW-8){w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{(DW-16){w_half[15]}}, w_half};
            F3_LW:   o_data = {{(DW-32){w_word[31]}}, w_word};
            F3_LBU:  o_data = {{(DW-8){1'b0}}, w_byte};
            F3_LHU:  o_data = {{(DW-16){1'b0}}, w_half};
            F3_LWU:  o_data = {{(DW-32){1'b0}}, w_word};
            default: o_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_ctrl.sv
// ============================================================================
// Module  : wb_ctrl
// Purpose : Writeback controller: register-file write port, busy scoreboard, instret.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_we,
    input  logic [AW-1:0]     ex_rd,
    input  logic [1:0]        ex_src,
    input  logic [2:0]        ex_funct3,
    input  logic [2:0]        ex_addr_lo,
    input  logic [DW-1:0]     ex_alu_data,
    input  logic [DW-1:0]     ex_pc_data,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [DW-1:0]     mem_rdata,
    output logic              wb_en,
    output logic              wb_load,
    output logic              wb_pc,
    output logic              wb_alu,
    output logic [AW-1:0]     wb_addr,
    output logic [DW-1:0]     load_data,
    output logic [DW-1:0]     pc_data,
    output logic [DW-1:0]     alu_data,
    output logic [2**AW-1:0]  busy,
    output logic [63:0]       instret
);

    state_t             r_state;
    state_t             w_next;
    logic               r_we;
    logic [AW-1:0]      r_rd;
    logic [1:0]         r_src;
    logic [2:0]         r_funct3;
    logic [2:0]         r_off;
    logic [DW-1:0]      r_alu;
    logic [DW-1:0]      r_pc;
    logic [DW-1:0]      r_load;
    logic [2**AW-1:0]   r_busy;
    logic [2**AW-1:0]   w_busy_nxt;
    logic [63:0]        r_instret;
    logic [DW-1:0]      w_ext;
    logic               w_accept;
    logic               w_commit;
    logic               w_load_hs;

    assign ex_ready   = (r_state != WAIT_LOAD);
    assign mem_rready = (r_state == WAIT_LOAD);
    assign w_accept   = ex_valid & ex_ready;
    assign w_commit   = (r_state == COMMIT);
    assign w_load_hs  = mem_rready & mem_rvalid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, COMMIT: begin
                if (w_accept) w_next = (ex_src == SRC_LOAD) ? WAIT_LOAD : COMMIT;
                else          w_next = IDLE;
            end
            WAIT_LOAD: if (mem_rvalid) w_next = COMMIT;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_src    <= SRC_ALU;
            r_funct3 <= '0;
            r_off    <= '0;
            r_alu    <= '0;
            r_pc     <= '0;
        end else if (w_accept) begin
            r_we     <= ex_we;
            r_rd     <= ex_rd;
            r_src    <= ex_src;
            r_funct3 <= ex_funct3;
            r_off    <= ex_addr_lo;
            r_alu    <= ex_alu_data;
            r_pc     <= ex_pc_data;
        end
    end

    wb_ctrl_load_ext #(.DW(DW)) u_load_ext (
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .i_rdata  (mem_rdata),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!rstn)          r_load <= '0;
        else if (w_load_hs) r_load <= w_ext;
    end

    // Clear for the retiring write first, then set for the new one so set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_commit) w_busy_nxt[r_rd] = 1'b0;
        if (w_accept && ex_we && (ex_rd != '0)) w_busy_nxt[ex_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_busy    <= '0;
            r_instret <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_commit) r_instret <= r_instret + 64'd1;
        end
    end

    assign wb_en     = w_commit & r_we & (r_rd != '0);
    assign wb_load   = w_commit & (r_src == SRC_LOAD);
    assign wb_pc     = w_commit & (r_src == SRC_PC);
    assign wb_alu    = w_commit & (r_src != SRC_LOAD) & (r_src != SRC_PC);
    assign wb_addr   = r_rd;
    assign load_data = r_load;
    assign pc_data   = r_pc;
    assign alu_data  = r_alu;
    assign busy      = r_busy;
    assign instret   = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_wb_ctrl.sv
// ============================================================================
// Module  : tb_wb_ctrl
// Purpose : Directed self-checking bench for wb_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_ctrl;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam logic [63:0] c_RDATA = 64'h0123_4567_89AB_CDEF;

    logic              clk = 1'b0;
    logic              rstn;
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_we;
    logic [AW-1:0]     ex_rd;
    logic [1:0]        ex_src;
    logic [2:0]        ex_funct3;
    logic [2:0]        ex_addr_lo;
    logic [DW-1:0]     ex_alu_data;
    logic [DW-1:0]     ex_pc_data;
    logic              mem_rvalid;
    logic              mem_rready;
    logic [DW-1:0]     mem_rdata;
    logic              wb_en;
    logic              wb_load;
    logic              wb_pc;
    logic              wb_alu;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     load_data;
    logic [DW-1:0]     pc_data;
    logic [DW-1:0]     alu_data;
    logic [2**AW-1:0]  busy;
    logic [63:0]       instret;

    int errors = 0;
    int checks = 0;

    wb_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we), .ex_rd(ex_rd),
        .ex_src(ex_src), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
        .ex_alu_data(ex_alu_data), .ex_pc_data(ex_pc_data),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_load(wb_load), .wb_pc(wb_pc), .wb_alu(wb_alu),
        .wb_addr(wb_addr), .load_data(load_data), .pc_data(pc_data),
        .alu_data(alu_data), .busy(busy), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] rd, input logic [1:0] src,
                         input logic [2:0] f3, input logic [2:0] off,
                         input logic [63:0] alu, input logic [63:0] pc);
        ex_valid = 1'b1; ex_we = we; ex_rd = rd; ex_src = src;
        ex_funct3 = f3; ex_addr_lo = off; ex_alu_data = alu; ex_pc_data = pc;
    endtask

    // Accept a load, answer it on the next cycle, leave the DUT in COMMIT.
    task automatic do_load(input logic [2:0] f3, input logic [2:0] off, input logic [AW-1:0] rd);
        issue(1'b1, rd, 2'd2, f3, off, 64'h0, 64'h0);
        step();
        ex_valid = 1'b0;
        mem_rdata = c_RDATA;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; ex_valid = 1'b0; ex_we = 1'b0; ex_rd = '0; ex_src = 2'd0;
        ex_funct3 = 3'd0; ex_addr_lo = 3'd0; ex_alu_data = '0; ex_pc_data = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_instret", instret, 64'h0);
        chk("rst_wb_en", 64'(wb_en), 64'h0);
        chk("rst_mem_rready", 64'(mem_rready), 64'h0);
        chk("rst_ex_ready", 64'(ex_ready), 64'h1);
        rstn = 1'b1;

        // Reset abandons a pending load
        issue(1'b1, 5'd3, 2'd2, 3'b000, 3'd1, 64'h0, 64'h0);
        step();
        ex_valid = 1'b0;
        chk("ml_rready", 64'(mem_rready), 64'h1);
        chk("ml_ex_ready", 64'(ex_ready), 64'h0);
        chk("ml_busy", 64'(busy), 64'h8);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("ml_rst_rready", 64'(mem_rready), 64'h0);
        chk("ml_rst_busy", 64'(busy), 64'h0);
        chk("ml_rst_ex_ready", 64'(ex_ready), 64'h1);
        mem_rdata = c_RDATA; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("ml_late_wb_en", 64'(wb_en), 64'h0);
        chk("ml_late_wb_load", 64'(wb_load), 64'h0);
        step();
        chk("ml_late_instret", instret, 64'h0);

        // Back-to-back ALU commits
        issue(1'b1, 5'd5, 2'd0, 3'd0, 3'd0, 64'h11, 64'h100);
        step();
        chk("alu1_wb_en", 64'(wb_en), 64'h1);
        chk("alu1_wb_alu", 64'(wb_alu), 64'h1);
        chk("alu1_addr", 64'(wb_addr), 64'd5);
        chk("alu1_data", alu_data, 64'h11);
        chk("alu1_busy", 64'(busy), 64'h20);
        issue(1'b1, 5'd6, 2'd0, 3'd0, 3'd0, 64'h22, 64'h104);
        step();
        ex_valid = 1'b0;
        chk("alu2_wb_en", 64'(wb_en), 64'h1);
        chk("alu2_addr", 64'(wb_addr), 64'd6);
        chk("alu2_data", alu_data, 64'h22);
        chk("alu2_busy", 64'(busy), 64'h40);
        chk("alu2_instret", instret, 64'd1);
        step();
        chk("alu_idle_wb_en", 64'(wb_en), 64'h0);
        chk("alu_idle_wb_alu", 64'(wb_alu), 64'h0);
        chk("alu_instret", instret, 64'd2);
        chk("alu_busy", 64'(busy), 64'h0);

        // lb off=1 answered three cycles after accept
        issue(1'b1, 5'd8, 2'd2, 3'b000, 3'd1, 64'h0, 64'h0);
        step();
        ex_valid = 1'b0;
        chk("lb_wait1_ready", 64'(ex_ready), 64'h0);
        step();
        chk("lb_wait2_ready", 64'(ex_ready), 64'h0);
        step();
        chk("lb_wait3_ready", 64'(ex_ready), 64'h0);
        mem_rdata = c_RDATA; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("lb_data", load_data, 64'hFFFF_FFFF_FFFF_FFCD);
        chk("lb_wb_load", 64'(wb_load), 64'h1);
        chk("lb_wb_en", 64'(wb_en), 64'h1);
        chk("lb_addr", 64'(wb_addr), 64'd8);
        chk("lb_busy", 64'(busy), 64'h100);

        do_load(3'b101, 3'd6, 5'd9);
        chk("lhu_data", load_data, 64'h0000_0000_0000_0123);
        do_load(3'b110, 3'd4, 5'd10);
        chk("lwu_data", load_data, 64'h0000_0000_0123_4567);
        do_load(3'b010, 3'd0, 5'd11);
        chk("lw_data", load_data, 64'hFFFF_FFFF_89AB_CDEF);
        do_load(3'b001, 3'd3, 5'd12);
        chk("lh_misaligned", load_data, 64'hFFFF_FFFF_FFFF_89AB);
        do_load(3'b011, 3'd5, 5'd13);
        chk("ld_data", load_data, c_RDATA);
        step();
        chk("loads_instret", instret, 64'd8);

        // jal-style pc writeback to x0
        issue(1'b1, 5'd0, 2'd1, 3'd0, 3'd0, 64'h0, 64'h2004);
        step();
        ex_valid = 1'b0;
        chk("x0_wb_en", 64'(wb_en), 64'h0);
        chk("x0_wb_pc", 64'(wb_pc), 64'h1);
        chk("x0_wb_alu", 64'(wb_alu), 64'h0);
        chk("x0_pc_data", pc_data, 64'h2004);
        chk("x0_busy", 64'(busy), 64'h0);
        step();
        chk("x0_instret", instret, 64'd9);

        // Reserved source behaves as ALU; we=0 neither writes nor marks busy
        issue(1'b0, 5'd4, 2'd3, 3'd0, 3'd0, 64'h44, 64'h0);
        step();
        ex_valid = 1'b0;
        chk("we0_wb_en", 64'(wb_en), 64'h0);
        chk("rsv_wb_alu", 64'(wb_alu), 64'h1);
        chk("we0_busy", 64'(busy), 64'h0);

        // Scoreboard collision: new rd=7 accepted while rd=7 commits
        issue(1'b1, 5'd7, 2'd0, 3'd0, 3'd0, 64'h70, 64'h0);
        step();
        chk("col1_busy", 64'(busy), 64'h80);
        issue(1'b1, 5'd7, 2'd0, 3'd0, 3'd0, 64'h77, 64'h0);
        step();
        ex_valid = 1'b0;
        chk("col2_busy", 64'(busy), 64'h80);
        chk("col2_data", alu_data, 64'h77);
        step();
        chk("col_busy_clear", 64'(busy), 64'h0);
        chk("col_instret", instret, 64'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
